// File: rtl/soc_arb_pkg.sv
// Shared definitions for the ROM port arbiter: master ids, default widths, debug view.
package soc_arb_pkg;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } master_e;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef struct packed {
      master_e    owner;
      logic [7:0] burst_cnt;
      logic [7:0] burst_lim;
      logic       fresh;
      logic       rd_pend;
      master_e    rd_owner;
   } arb_dbg_t;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Bundle of both master ports and the memory port of the ROM arbiter.
// Handshake: a transfer is accepted when mN_req_i and mN_gnt_o are high in the same cycle;
// the requester holds req/addr/we/wdata stable until granted, and read data returns with rvalid one cycle later.
interface rom_port_arbiter_if
   import soc_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              m0_req_i;
   logic [ADDR_W-1:0] m0_addr_i;
   logic              m0_gnt_o;
   logic              m0_rvalid_o;
   logic [DATA_W-1:0] m0_rdata_o;

   logic              m1_req_i;
   logic              m1_we_i;
   logic [ADDR_W-1:0] m1_addr_i;
   logic [DATA_W-1:0] m1_wdata_i;
   logic              m1_gnt_o;
   logic              m1_rvalid_o;
   logic [DATA_W-1:0] m1_rdata_o;

   logic              mem_ce_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;

   // arbiter side
   modport slave (
      input  m0_req_i, m0_addr_i,
      input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
      input  mem_rdata_i,
      output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
      output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
      output mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   // requesters plus memory side
   modport master (
      output m0_req_i, m0_addr_i,
      output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
      output mem_rdata_i,
      input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
      input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
      input  mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

endinterface

// File: rtl/rom_port_arbiter.sv
// Two-master arbiter for the shared single-port ROM array: m0 = core fetch (read-only), m1 = loader (r/w).
// Define ARB_ROUND_ROBIN_EN for burst-limited round robin; otherwise m0 has fixed priority.
module rom_port_arbiter
   import soc_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   rom_port_arbiter_if.slave bus,
   output arb_dbg_t          dbg
);

   logic              gnt0;
   logic              gnt1;
   logic              accept;
   logic              rd_accept;
   master_e           gnt_id;
   logic              rd_pend;
   master_e           rd_owner;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
   localparam int               CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAX_BURST - 1);

   master_e          owner;
   master_e          owner_nxt;
   master_e          eff_owner;
   logic [CNT_W-1:0] burst_cnt;
   logic [CNT_W-1:0] burst_nxt;
   logic             fresh;
   logic             fresh_nxt;
   logic             contend;

   // Straight out of reset the stored owner is M1 but no burst is running yet,
   // so the first tie goes to m0 and counts as the first beat of its burst.
   always_comb begin
      contend   = bus.m0_req_i && bus.m1_req_i;
      eff_owner = fresh ? M0 : owner;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      if (!rst) begin
         if (contend) begin
            gnt0 = (eff_owner == M0);
            gnt1 = (eff_owner == M1);
         end else begin
            gnt0 = bus.m0_req_i;
            gnt1 = bus.m1_req_i;
         end
      end
   end

   always_comb begin
      owner_nxt = owner;
      burst_nxt = burst_cnt;
      fresh_nxt = fresh;
      if (accept) begin
         fresh_nxt = 1'b0;
         if (!contend) begin
            owner_nxt = gnt_id;
            burst_nxt = '0;
         end else if (burst_cnt == LAST) begin
            owner_nxt = (gnt_id == M0) ? M1 : M0;
            burst_nxt = '0;
         end else begin
            owner_nxt = gnt_id;
            burst_nxt = burst_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner     <= M1;
         burst_cnt <= '0;
         fresh     <= 1'b1;
      end else begin
         owner     <= owner_nxt;
         burst_cnt <= burst_nxt;
         fresh     <= fresh_nxt;
      end
   end

   assign dbg.owner     = owner;
   assign dbg.burst_cnt = 8'(burst_cnt);
   assign dbg.fresh     = fresh;
`else
   assign gnt0 = !rst && bus.m0_req_i;
   assign gnt1 = !rst && bus.m1_req_i && !bus.m0_req_i;

   assign dbg.owner     = M1;
   assign dbg.burst_cnt = 8'd0;
   assign dbg.fresh     = 1'b0;
`endif

   assign accept    = gnt0 || gnt1;
   assign gnt_id    = gnt1 ? M1 : M0;
   assign rd_accept = gnt0 || (gnt1 && !bus.m1_we_i);

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      if (gnt1) begin
         sel_addr  = bus.m1_addr_i;
         sel_wdata = bus.m1_wdata_i;
      end else if (gnt0) begin
         sel_addr  = bus.m0_addr_i;
      end
   end

   // Async reset drops any read in flight so its rvalid never appears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend  <= 1'b0;
         rd_owner <= M0;
      end else begin
         rd_pend  <= rd_accept;
         rd_owner <= rd_accept ? gnt_id : rd_owner;
      end
   end

   assign bus.m0_gnt_o    = gnt0;
   assign bus.m1_gnt_o    = gnt1;
   assign bus.mem_ce_o    = accept;
   assign bus.mem_we_o    = gnt1 && bus.m1_we_i;
   assign bus.mem_addr_o  = sel_addr;
   assign bus.mem_wdata_o = sel_wdata;

   assign bus.m0_rvalid_o = rd_pend && (rd_owner == M0);
   assign bus.m1_rvalid_o = rd_pend && (rd_owner == M1);
   assign bus.m0_rdata_o  = bus.m0_rvalid_o ? bus.mem_rdata_i : '0;
   assign bus.m1_rdata_o  = bus.m1_rvalid_o ? bus.mem_rdata_i : '0;

   assign dbg.burst_lim = 8'(MAX_BURST);
   assign dbg.rd_pend   = rd_pend;
   assign dbg.rd_owner  = rd_owner;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed vectors, a per-cycle arbitration/return model,
// and literal expectations for grant order and returned data. Follows ARB_ROUND_ROBIN_EN like the DUT.
module tb_rom_port_arbiter;
   import soc_arb_pkg::*;

   localparam int MB = 4;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rom_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   arb_dbg_t dbg;

   rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave),
      .dbg (dbg)
   );

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [31:0] init_word(input int idx);
      return 32'h1000_0000 | 32'(idx);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // memory environment: synchronous read, data valid the cycle after the strobe
   logic [31:0] env_mem [int];
   always @(posedge clk) begin
      int idx;
      idx = int'(bus.mem_addr_o[7:2]);
      if (bus.mem_ce_o) begin
         if (bus.mem_we_o) env_mem[idx] = bus.mem_wdata_o;
         else bus.mem_rdata_i <= env_mem.exists(idx) ? env_mem[idx] : init_word(idx);
      end
   end

   // behavioural model state and scoreboard
   logic [31:0] ref_mem [int];
   logic [31:0] exp_q[$];
   int          own_q[$];
   int          holder = 0;
   int          streak = 0;
   int          gnt_log[$];
   logic [31:0] got0_q[$];
   logic [31:0] got1_q[$];

   always @(negedge clk) begin
      int          w;
      int          o;
      int          idx;
      logic [31:0] d;
      logic [31:0] a;
      if (rst) begin
         chk("rst_m0_gnt", bus.m0_gnt_o, 0);
         chk("rst_m1_gnt", bus.m1_gnt_o, 0);
         chk("rst_m0_rvalid", bus.m0_rvalid_o, 0);
         chk("rst_m1_rvalid", bus.m1_rvalid_o, 0);
         chk("rst_m0_rdata", bus.m0_rdata_o, 0);
         chk("rst_m1_rdata", bus.m1_rdata_o, 0);
         chk("rst_mem_ce", bus.mem_ce_o, 0);
         chk("rst_mem_we", bus.mem_we_o, 0);
         chk("rst_mem_addr", bus.mem_addr_o, 0);
         chk("rst_mem_wdata", bus.mem_wdata_o, 0);
         exp_q.delete();
         own_q.delete();
         holder = 0;
         streak = 0;
      end else begin
         if (exp_q.size() > 0) begin
            d = exp_q.pop_front();
            o = own_q.pop_front();
         end else begin
            d = '0;
            o = -1;
         end
         chk("m0_rvalid", bus.m0_rvalid_o, 32'(o == 0));
         chk("m1_rvalid", bus.m1_rvalid_o, 32'(o == 1));
         chk("m0_rdata", bus.m0_rdata_o, (o == 0) ? d : 32'h0);
         chk("m1_rdata", bus.m1_rdata_o, (o == 1) ? d : 32'h0);
         if (bus.m0_rvalid_o) got0_q.push_back(bus.m0_rdata_o);
         if (bus.m1_rvalid_o) got1_q.push_back(bus.m1_rdata_o);

         w = -1;
`ifdef ARB_ROUND_ROBIN_EN
         // tie: the current holder keeps the port for MB consecutive accepts, then yields
         if (bus.m0_req_i && bus.m1_req_i) begin
            if (streak == MB) begin
               holder = 1 - holder;
               streak = 0;
            end
            w = holder;
            streak++;
         end else if (bus.m0_req_i || bus.m1_req_i) begin
            w      = bus.m0_req_i ? 0 : 1;
            holder = w;
            streak = 0;
         end
`else
         if (bus.m0_req_i) w = 0;
         else if (bus.m1_req_i) w = 1;
`endif
         chk("m0_gnt", bus.m0_gnt_o, 32'(w == 0));
         chk("m1_gnt", bus.m1_gnt_o, 32'(w == 1));
         chk("mem_ce", bus.mem_ce_o, 32'(w >= 0));
         chk("mem_we", bus.mem_we_o, 32'((w == 1) && bus.m1_we_i));
         if (w >= 0) begin
            gnt_log.push_back(w);
            a   = (w == 0) ? bus.m0_addr_i : bus.m1_addr_i;
            idx = int'(a[7:2]);
            chk("mem_addr", bus.mem_addr_o, a);
            if (w == 1 && bus.m1_we_i) begin
               chk("mem_wdata", bus.mem_wdata_o, bus.m1_wdata_i);
               ref_mem[idx] = bus.m1_wdata_i;
            end else begin
               exp_q.push_back(ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx));
               own_q.push_back(w);
            end
         end
      end
   end

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m0(input logic r, input logic [31:0] a);
      bus.m0_req_i  = r;
      bus.m0_addr_i = a;
   endtask

   task automatic set_m1(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
      bus.m1_req_i   = r;
      bus.m1_we_i    = we;
      bus.m1_addr_i  = a;
      bus.m1_wdata_i = d;
   endtask

   task automatic clear_logs();
      gnt_log.delete();
      got0_q.delete();
      got1_q.delete();
   endtask

   task automatic check_seq(input string name, input string s);
      chk({name, "_len"}, gnt_log.size(), s.len());
      for (int i = 0; i < s.len(); i++)
         chk(name, (i < gnt_log.size()) ? gnt_log[i] : -1, int'(s[i]) - 48);
   endtask

   task automatic check_data(input string name, input logic [31:0] got[$], input logic [31:0] exp[$]);
      chk({name, "_cnt"}, got.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         chk(name, (i < got.size()) ? got[i] : 32'hxxxx_xxxx, exp[i]);
   endtask

   logic [31:0] lit_q[$];
   logic [31:0] none_q[$];

   initial begin
      set_m0(1'b1, 32'h0);
      set_m1(1'b1, 1'b0, 32'h0, 32'h0);
      bus.mem_rdata_i = '0;

      // reset with both requesting: no grant may escape
      repeat (3) cyc();
      chk("rst_gnt_forced_m0", bus.m0_gnt_o, 0);
      chk("rst_gnt_forced_m1", bus.m1_gnt_o, 0);
      chk("rst_dbg_rd_pend", dbg.rd_pend, 0);
      chk("dbg_burst_lim", dbg.burst_lim, MB);
`ifdef ARB_ROUND_ROBIN_EN
      chk("rst_dbg_owner", dbg.owner, M1);
      chk("rst_dbg_burst", dbg.burst_cnt, 0);
`endif
      set_m0(1'b0, 32'h0);
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b0;
      cyc();

      // m0 reads 0x0, 0x4, 0x8 back to back
      clear_logs();
      for (int i = 0; i < 3; i++) begin
         set_m0(1'b1, 32'(i * 4));
         cyc();
      end
      set_m0(1'b0, 32'h0);
      repeat (2) cyc();
      check_seq("t1_gnt", "000");
      lit_q = {32'h1000_0000, 32'h1000_0001, 32'h1000_0002};
      check_data("t1_m0_data", got0_q, lit_q);

      // m1 write then read of the same word
      clear_logs();
      set_m1(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
      cyc();
      set_m1(1'b1, 1'b0, 32'h10, 32'h0);
      cyc();
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) cyc();
      check_seq("t2_gnt", "11");
      lit_q = {32'hDEAD_BEEF};
      check_data("t2_m1_data", got1_q, lit_q);
      check_data("t2_m0_none", got0_q, none_q);

      // both request continuously from reset, then m0 drops
      rst = 1'b1;
      repeat (2) cyc();
      rst = 1'b0;
      clear_logs();
      set_m0(1'b1, 32'h20);
      set_m1(1'b1, 1'b0, 32'h40, 32'h0);
      repeat (12) cyc();
      set_m0(1'b0, 32'h0);
      cyc();
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) cyc();
`ifdef ARB_ROUND_ROBIN_EN
      check_seq("t3_gnt", "0000111100001");
      chk("t3_m0_rvalids", got0_q.size(), 8);
      chk("t3_m1_rvalids", got1_q.size(), 5);
`else
      check_seq("t3_gnt", "0000000000001");
      chk("t3_m0_rvalids", got0_q.size(), 12);
      chk("t3_m1_rvalids", got1_q.size(), 1);
`endif

      // m1 read accepted, then a 1-cycle reset pulse while m0 waits
      clear_logs();
      set_m1(1'b1, 1'b0, 32'h14, 32'h0);
      cyc();
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);
      set_m0(1'b1, 32'h18);
      rst = 1'b1;
      #1;
      chk("t4_rst_m1_rvalid", bus.m1_rvalid_o, 0);
      chk("t4_rst_dbg_rd_pend", dbg.rd_pend, 0);
      cyc();
      rst = 1'b0;
      cyc();
      set_m0(1'b0, 32'h0);
      repeat (3) cyc();
      check_seq("t4_gnt", "10");
      check_data("t4_m1_none", got1_q, none_q);
      lit_q = {32'h1000_0006};
      check_data("t4_m0_data", got0_q, lit_q);

      // m0 holds the port for two tied beats, then drops while m1 waits
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      clear_logs();
      set_m0(1'b1, 32'h0);
      set_m1(1'b1, 1'b0, 32'h4, 32'h0);
      repeat (2) cyc();
`ifdef ARB_ROUND_ROBIN_EN
      chk("t5_owner_mid", dbg.owner, M0);
      chk("t5_burst_mid", dbg.burst_cnt, 2);
`endif
      set_m0(1'b0, 32'h0);
      #1;
      chk("t5_m1_gnt_same_cycle", bus.m1_gnt_o, 1);
      chk("t5_m0_gnt_same_cycle", bus.m0_gnt_o, 0);
      cyc();
`ifdef ARB_ROUND_ROBIN_EN
      chk("t5_owner_after", dbg.owner, M1);
      chk("t5_burst_after", dbg.burst_cnt, 0);
`endif
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) cyc();
      check_seq("t5_gnt", "001");

      // mixed traffic: m1 write becomes visible to both readers
      clear_logs();
      set_m1(1'b1, 1'b1, 32'h30, 32'h1234_5678);
      cyc();
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);
      set_m0(1'b1, 32'h30);
      cyc();
      set_m0(1'b0, 32'h0);
      set_m1(1'b1, 1'b0, 32'h30, 32'h0);
      cyc();
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);
      set_m0(1'b1, 32'h34);
      cyc();
      set_m0(1'b0, 32'h0);
      repeat (2) cyc();
      check_seq("t6_gnt", "1010");
      lit_q = {32'h1234_5678, 32'h1000_000D};
      check_data("t6_m0_data", got0_q, lit_q);
      lit_q = {32'h1234_5678};
      check_data("t6_m1_data", got1_q, lit_q);

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Two-master arbiter sharing the SoC's single-port instruction/data memory (the ROM array) between the core fetch path (m0, read-only) and a loader/debug master (m1, read/write). It grants one accepted access per cycle, drives the memory port from the selected master and returns synchronous read data to the correct owner one cycle later. It sits between `open_risc_v` and `rom` inside `open_risc_v_soc`, so test images can be loaded or inspected while the core runs.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_BURST, 4, max consecutive accepts by the owner while the other master waits (≥1)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- m0_req_i  in  1  core fetch request
- m0_addr_i  in  ADDR_W  core fetch address
- m0_gnt_o  out  1  m0 request accepted this cycle
- m0_rvalid_o  out  1  m0 read data valid
- m0_rdata_o  out  DATA_W  m0 read data
- m1_req_i  in  1  loader request
- m1_we_i  in  1  1 = write, 0 = read
- m1_addr_i  in  ADDR_W  loader address
- m1_wdata_i  in  DATA_W  loader write data
- m1_gnt_o  out  1  m1 request accepted this cycle
- m1_rvalid_o  out  1  m1 read data valid
- m1_rdata_o  out  DATA_W  m1 read data
- mem_ce_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid the cycle after a read strobe

## Operation
- Handshake: a transfer is accepted when mN_req_i and mN_gnt_o are both high in the same cycle. A requester holds req/addr/we/wdata stable until granted. At most one gnt is high per cycle.
- State: owner (M0/M1), burst_cnt (0..MAX_BURST-1), rd_pend, rd_owner.
- Grant rules, evaluated combinationally each cycle:
  - Only one master requesting: that master is granted.
  - Both requesting, burst_cnt < MAX_BURST-1: the owner is granted.
  - Both requesting, burst_cnt == MAX_BURST-1: the owner is granted this one last time; ownership then passes to the other master.
- Ownership and burst counter updates on each accept:
  - Grant to the non-owner: owner takes that master, burst_cnt = 0.
  - Grant to the owner while the other master requests: burst_cnt increments, or clears to 0 with ownership switching when it was MAX_BURST-1.
  - Grant to the owner with the other master idle: burst_cnt clears.
- Memory port: the selected master's addr/wdata/we drive mem_*. mem_ce_o = accept. m0 accepts always have mem_we_o = 0.
- Read return: on an accepted read, rd_pend <= 1 and rd_owner <= granted master. Next cycle, that master's rvalid is 1 and its rdata = mem_rdata_i, passed through combinationally. The non-owner's rdata is 0. Writes produce no rvalid.
- Back-to-back reads are supported: one rvalid per cycle, in order.

## Timing
- Reset values:
  - owner = M1, so m0 wins the first tie.
  - burst_cnt = 0, rd_pend = 0.
  - All gnt, rvalid and mem_ce/we outputs are 0.
  - mem_addr/wdata and rdata outputs are 0.
- gnt is forced to 0 while rst is high.
- Grant latency is 0 cycles: gnt is combinational from req and state.
- Read latency is exactly 1 cycle from accept to rvalid.
- Reset asserted mid-read: the pending rvalid is dropped and never appears after reset releases.
- Owner drops req mid-burst: the other master is granted in the same cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined: the burst-limited round-robin rules above apply.
- ARB_ROUND_ROBIN_EN undefined: fixed priority.
  - m0 always wins when both request; m1 is granted only in cycles where m0_req_i = 0.
  - owner and burst_cnt are not implemented.
  - Read return behaviour is unchanged.

## Structure
- Shared package `soc_arb_pkg`:
  - master-id typedef (M0 = 0, M1 = 1)
  - default ADDR_W/DATA_W constants
- Sub-module: none. Grant logic, counter and return pipe together are about 150 lines in one module.

## Test plan
- m0 reads 0x0, 0x4, 0x8 on consecutive cycles with m1 idle -> three gnts; m0_rvalid_o high cycles 2–4 with the memory contents in order; mem_we_o stays 0.
- m1 writes 0xDEADBEEF to 0x10, then m1 reads 0x10 -> the read accepted the next cycle returns m1_rdata_o = 0xDEADBEEF with m1_rvalid_o, and no m0_rvalid_o.
- Both request continuously from reset, round-robin enabled, MAX_BURST = 4 -> grant sequence m0×4, m1×4, m0×4; rvalid goes to the matching owner each cycle.
- Same stimulus with ARB_ROUND_ROBIN_EN undefined -> m0 granted every cycle, m1 never; m1 is granted in the first cycle after m0_req_i drops.
- m1 read accepted, then rst pulsed high for 1 cycle -> no rvalid on either master after reset; all outputs 0 while rst is high.
- m0 owns with burst_cnt = 2, then m0 drops req while m1 requests -> m1_gnt_o high the same cycle and burst_cnt restarts at 0.
